// File: rtl/csa_wide_add_seq_pkg.sv
// ---------------------------------------------------------------------------
// csa_wide_add_seq_pkg
//
// Purpose:
//   Shared definitions for the csa family of blocks: the slice width that the
//   16-bit csa works on, the controller state encoding and a small helper for
//   two's-complement overflow detection.
//
// Contents:
//   SLICE_W          width of one csa pass (16)
//   state_t          IDLE / RUN / DONE controller states (2'd3 unused)
//   signed_overflow  overflow from operand MSBs and result MSB
// ---------------------------------------------------------------------------
package csa_wide_add_seq_pkg;

    // Width of the single csa instance; operands are processed in chunks of
    // this many bits, least significant chunk first.
    localparam int SLICE_W = 16;

    // Controller states. Encoding 2'd3 is never entered on purpose and is
    // decoded as IDLE so a corrupted state register recovers on its own.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Two's-complement overflow: both operands carry the same sign but the
    // result comes out with the opposite sign.
    function automatic logic signed_overflow(
        input logic a_msb,
        input logic b_msb,
        input logic sum_msb
    );
        return (a_msb == b_msb) && (sum_msb != a_msb);
    endfunction

endpackage

// File: rtl/csa_wide_add_seq_csa.sv
// ---------------------------------------------------------------------------
// csa_wide_add_seq_csa
//
// Purpose:
//   The 16-bit carry-select adder that the wide sequential adder time-shares.
//   Purely combinational. The slice is split into 4-bit blocks; each block
//   precomputes its sum for an incoming carry of 0 and of 1, and the real
//   carry from the block below picks one of the two.
//
// Ports:
//   a          in   SLICE_W  operand A slice
//   b          in   SLICE_W  operand B slice
//   carry_in   in   1        carry into bit 0 of the slice
//   sum        out  SLICE_W  (a + b + carry_in) mod 2^SLICE_W
//   carry_out  out  1        carry out of the top bit of the slice
// ---------------------------------------------------------------------------
module csa_wide_add_seq_csa
    import csa_wide_add_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               carry_in,
    output logic [SLICE_W-1:0] sum,
    output logic               carry_out
);

    localparam int BLOCK_W = 4;
    localparam int NBLK    = SLICE_W / BLOCK_W;

    // carry[i] is the carry entering block i; carry[NBLK] leaves the slice.
    logic [NBLK:0] carry;

    assign carry[0] = carry_in;

    // Each block computes both candidate results in parallel so that only the
    // select mux sits on the block-to-block carry path.
    for (genvar i = 0; i < NBLK; i++) begin : g_block
        logic [BLOCK_W:0] sum_c0;
        logic [BLOCK_W:0] sum_c1;

        assign sum_c0 = {1'b0, a[i*BLOCK_W +: BLOCK_W]}
                      + {1'b0, b[i*BLOCK_W +: BLOCK_W]};
        assign sum_c1 = sum_c0 + {{BLOCK_W{1'b0}}, 1'b1};

        assign sum[i*BLOCK_W +: BLOCK_W] = carry[i] ? sum_c1[BLOCK_W-1:0]
                                                    : sum_c0[BLOCK_W-1:0];
        assign carry[i+1] = carry[i] ? sum_c1[BLOCK_W] : sum_c0[BLOCK_W];
    end

    assign carry_out = carry[NBLK];

endmodule

// File: rtl/csa_wide_add_seq.sv
// ---------------------------------------------------------------------------
// csa_wide_add_seq
//
// Purpose:
//   Multi-cycle WIDTH-bit adder built around one 16-bit csa. An operand pair
//   is accepted through a valid/ready handshake, then one 16-bit slice per
//   cycle is pushed through the csa, least significant slice first, with the
//   csa carry-out fed back as the next slice's carry-in. The finished sum,
//   carry-out and signed-overflow flag are presented through a valid/ready
//   output handshake. Operations never overlap.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      operand pair valid
//   in_ready   out  1      high only in IDLE
//   in_a       in   WIDTH  operand A
//   in_b       in   WIDTH  operand B
//   in_cin     in   1      carry into bit 0
//   out_valid  out  1      result valid, held until out_ready
//   out_ready  in   1      consumer takes the result
//   out_sum    out  WIDTH  A + B + cin, mod 2^WIDTH
//   out_cout   out  1      carry out of bit WIDTH-1
//   out_ovf    out  1      signed overflow of the addition
//
// WIDTH must be an integer multiple of SLICE_W.
// ---------------------------------------------------------------------------
module csa_wide_add_seq
    import csa_wide_add_seq_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t state;
    state_t state_next;

    // Control strobes decoded from the state machine.
    logic accept;
    logic step;
    logic last_step;

    // Captured operands and the running computation.
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] res_next;
    logic             carry_reg;
    logic [IDX_W-1:0] idx;

    // Published result; kept apart from res_reg so the half-built value
    // of an operation in flight never shows on out_sum.
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    // Slice currently routed through the csa.
    logic [SLICE_W-1:0] csa_a;
    logic [SLICE_W-1:0] csa_b;
    logic [SLICE_W-1:0] csa_sum;
    logic               csa_cout;

    // The state register. Reset always lands in IDLE, even if a handshake
    // happens in the same cycle, which abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode. IDLE is also the fallback for the
    // unused encoding, so a stray state heads straight back to IDLE.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        step       = 1'b0;
        last_step  = 1'b0;

        case (state)
            ST_RUN: begin
                step = 1'b1;
                if (idx == LAST_IDX) begin
                    last_step  = 1'b1;
                    state_next = ST_DONE;
                end
            end

            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
                in_ready   = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end
            end
        endcase
    end

    // Feed the csa with the slice selected by idx. Slice 0 sees the
    // registered cin because accept loads it into carry_reg; later slices
    // see the carry left behind by the previous pass.
    assign csa_a = a_reg[idx*SLICE_W +: SLICE_W];
    assign csa_b = b_reg[idx*SLICE_W +: SLICE_W];

    csa_wide_add_seq_csa u_csa (
        .a         (csa_a),
        .b         (csa_b),
        .carry_in  (carry_reg),
        .sum       (csa_sum),
        .carry_out (csa_cout)
    );

    // Running result with the current slice merged in. On the last pass
    // this is the complete sum, which lets it be published on the same edge.
    always_comb begin
        res_next = res_reg;
        res_next[idx*SLICE_W +: SLICE_W] = csa_sum;
    end

    // Datapath registers. Accept captures the operands so the producer may
    // change its inputs right away; each RUN cycle retires one slice; the
    // last slice also loads the published result and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (accept) begin
                a_reg     <= in_a;
                b_reg     <= in_b;
                carry_reg <= in_cin;
                res_reg   <= '0;
                idx       <= '0;
            end

            if (step) begin
                res_reg   <= res_next;
                carry_reg <= csa_cout;
                if (idx != LAST_IDX) begin
                    idx <= idx + 1'b1;
                end
            end

            if (last_step) begin
                sum_q  <= res_next;
                cout_q <= csa_cout;
                ovf_q  <= signed_overflow(a_reg[WIDTH-1], b_reg[WIDTH-1],
                                          res_next[WIDTH-1]);
            end
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;
    assign out_ovf  = ovf_q;

endmodule
